// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among completing functional units,
// with the winner's result registered onto the CDB one cycle later.
module cdb_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TAG_WIDTH  = 6
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_flush,
   input  logic [NUM_REQ-1:0]              i_req_valid,
   input  logic [NUM_REQ*TAG_WIDTH-1:0]    i_req_tag,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_data,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   i_req_addr,
   input  logic [NUM_REQ-1:0]              i_req_redirect,
   output logic [NUM_REQ-1:0]              o_req_grant,
   output logic                            o_cdb_en,
   output logic [TAG_WIDTH-1:0]            o_cdb_tag,
   output logic [DATA_WIDTH-1:0]           o_cdb_data,
   output logic [ADDR_WIDTH-1:0]           o_cdb_addr,
   output logic                            o_cdb_redirect
);

   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]      ptr;
   logic [PTR_W-1:0]      win_p0;
   logic                  vld_p0;
   logic [NUM_REQ-1:0]    grant_p0;
   logic [PTR_W-1:0]      ptr_next_p0;
   logic [TAG_WIDTH-1:0]  tag_p0;
   logic [DATA_WIDTH-1:0] data_p0;
   logic [ADDR_WIDTH-1:0] addr_p0;
   logic                  redir_p0;

   logic                  vld_p1;
   logic [TAG_WIDTH-1:0]  tag_p1;
   logic [DATA_WIDTH-1:0] data_p1;
   logic [ADDR_WIDTH-1:0] addr_p1;
   logic                  redir_p1;

   // Stage p0: round-robin pick. The second pass (indices >= ptr) overrides the
   // first (indices < ptr), so the lowest index at or above ptr wins, else wrap.
   always_comb begin
      vld_p0 = 1'b0;
      win_p0 = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (i_req_valid[j] && (PTR_W'(j) < ptr)) begin
            vld_p0 = 1'b1;
            win_p0 = PTR_W'(j);
         end
      end
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (i_req_valid[j] && (PTR_W'(j) >= ptr)) begin
            vld_p0 = 1'b1;
            win_p0 = PTR_W'(j);
         end
      end
      if (rst || i_flush) begin
         vld_p0 = 1'b0;
      end
   end

   always_comb begin
      grant_p0 = '0;
      if (vld_p0) begin
         grant_p0[win_p0] = 1'b1;
      end
      ptr_next_p0 = (win_p0 == PTR_W'(NUM_REQ - 1)) ? '0 : win_p0 + 1'b1;
   end

   always_comb begin
      tag_p0   = '0;
      data_p0  = '0;
      addr_p0  = '0;
      redir_p0 = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (grant_p0[j]) begin
            tag_p0   = i_req_tag[j*TAG_WIDTH +: TAG_WIDTH];
            data_p0  = i_req_data[j*DATA_WIDTH +: DATA_WIDTH];
            addr_p0  = i_req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
            redir_p0 = i_req_redirect[j];
         end
      end
   end

   // Stage p1: broadcast register; payload holds when nothing is granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr      <= '0;
         vld_p1   <= 1'b0;
         tag_p1   <= '0;
         data_p1  <= '0;
         addr_p1  <= '0;
         redir_p1 <= 1'b0;
      end else begin
         vld_p1 <= vld_p0;
         if (vld_p0) begin
            ptr      <= ptr_next_p0;
            tag_p1   <= tag_p0;
            data_p1  <= data_p0;
            addr_p1  <= addr_p0;
            redir_p1 <= redir_p0;
         end
      end
   end

   assign o_req_grant    = grant_p0;
   assign o_cdb_en       = vld_p1;
   assign o_cdb_tag      = tag_p1;
   assign o_cdb_data     = data_p1;
   assign o_cdb_addr     = addr_p1;
   assign o_cdb_redirect = redir_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: vector table with hard-coded expected grants, broadcast
// expectations queued at grant time and compared one cycle later.
module tb_cdb_arbiter;

   localparam int NR = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_flush;
   logic [NR-1:0] i_req_valid;
   logic [NR*6-1:0]  i_req_tag;
   logic [NR*32-1:0] i_req_data;
   logic [NR*32-1:0] i_req_addr;
   logic [NR-1:0] i_req_redirect;
   logic [NR-1:0] o_req_grant;
   logic          o_cdb_en;
   logic [5:0]    o_cdb_tag;
   logic [31:0]   o_cdb_data;
   logic [31:0]   o_cdb_addr;
   logic          o_cdb_redirect;

   cdb_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(32), .ADDR_WIDTH(32), .TAG_WIDTH(6)) dut (
      .clk(clk), .rst(rst), .i_flush(i_flush),
      .i_req_valid(i_req_valid), .i_req_tag(i_req_tag), .i_req_data(i_req_data),
      .i_req_addr(i_req_addr), .i_req_redirect(i_req_redirect),
      .o_req_grant(o_req_grant), .o_cdb_en(o_cdb_en), .o_cdb_tag(o_cdb_tag),
      .o_cdb_data(o_cdb_data), .o_cdb_addr(o_cdb_addr), .o_cdb_redirect(o_cdb_redirect)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        flush;
      logic [2:0]  valid;
      logic [2:0]  redir;
      logic [5:0]  t0, t1, t2;
      logic [31:0] dbase;
      logic [31:0] abase;
      logic [2:0]  exp_grant;
   } vec_t;

   typedef struct packed {
      logic        en;
      logic [5:0]  tag;
      logic [31:0] data;
      logic [31:0] addr;
      logic        redir;
   } cdb_t;

   int   checks = 0;
   int   failures = 0;
   cdb_t q[$];
   cdb_t last;
   vec_t vecs[24];

   function automatic vec_t mk(logic r, logic f, logic [2:0] v, logic [2:0] rd,
                               logic [5:0] t2, logic [5:0] t1, logic [5:0] t0,
                               logic [31:0] db, logic [31:0] ab, logic [2:0] g);
      vec_t x;
      x.rst = r; x.flush = f; x.valid = v; x.redir = rd;
      x.t0 = t0; x.t1 = t1; x.t2 = t2; x.dbase = db; x.abase = ab; x.exp_grant = g;
      return x;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Drive one vector: grant checked mid-cycle, broadcast checked after the edge.
   task automatic run_vec(vec_t v, int idx);
      cdb_t e;
      int   w;
      rst            = v.rst;
      i_flush        = v.flush;
      i_req_valid    = v.valid;
      i_req_redirect = v.redir;
      i_req_tag      = {v.t2, v.t1, v.t0};
      i_req_data     = {v.dbase + 32'd2, v.dbase + 32'd1, v.dbase};
      i_req_addr     = {v.abase + 32'd8, v.abase + 32'd4, v.abase};
      @(negedge clk);
      chk($sformatf("grant[%0d]", idx), 32'(o_req_grant), 32'(v.exp_grant));
      if (v.flush && !v.rst)
         chk($sformatf("flush_cycle_en[%0d]", idx), 32'(o_cdb_en), 32'(last.en));
      w = v.exp_grant[2] ? 2 : (v.exp_grant[1] ? 1 : 0);
      e = last;
      if (v.rst) begin
         e = '0;
      end else if (v.exp_grant != 3'b000) begin
         e.en    = 1'b1;
         e.tag   = (w == 0) ? v.t0 : ((w == 1) ? v.t1 : v.t2);
         e.data  = v.dbase + 32'(w);
         e.addr  = v.abase + 32'(4 * w);
         e.redir = v.redir[w];
      end else begin
         e.en = 1'b0;
      end
      q.push_back(e);
      last = e;
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
         chk($sformatf("queue_empty[%0d]", idx), 32'd1, 32'd0);
      end else begin
         e = q.pop_front();
         chk($sformatf("cdb_en[%0d]", idx),    32'(o_cdb_en),       32'(e.en));
         chk($sformatf("cdb_tag[%0d]", idx),   32'(o_cdb_tag),      32'(e.tag));
         chk($sformatf("cdb_data[%0d]", idx),  o_cdb_data,          e.data);
         chk($sformatf("cdb_addr[%0d]", idx),  o_cdb_addr,          e.addr);
         chk($sformatf("cdb_redir[%0d]", idx), 32'(o_cdb_redirect), 32'(e.redir));
      end
   endtask

   initial begin
      //             rst flush valid   redir   t2     t1     t0    dbase         abase         grant
      vecs[0]  = mk(1, 0, 3'b111, 3'b000, 6'd17, 6'd9,  6'd5, 32'h1000_0000, 32'h2000_0000, 3'b000);
      vecs[1]  = mk(1, 0, 3'b111, 3'b000, 6'd17, 6'd9,  6'd5, 32'h1000_0000, 32'h2000_0000, 3'b000);
      vecs[2]  = mk(0, 0, 3'b111, 3'b000, 6'd17, 6'd9,  6'd5, 32'h1000_0000, 32'h2000_0000, 3'b001);
      vecs[3]  = mk(0, 0, 3'b111, 3'b000, 6'd17, 6'd9,  6'd5, 32'h1000_0010, 32'h2000_0010, 3'b010);
      vecs[4]  = mk(0, 0, 3'b111, 3'b000, 6'd17, 6'd9,  6'd5, 32'h1000_0020, 32'h2000_0020, 3'b100);
      vecs[5]  = mk(0, 0, 3'b111, 3'b000, 6'd17, 6'd9,  6'd5, 32'h1000_0030, 32'h2000_0030, 3'b001);
      vecs[6]  = mk(0, 0, 3'b111, 3'b000, 6'd17, 6'd9,  6'd5, 32'h1000_0040, 32'h2000_0040, 3'b010);
      vecs[7]  = mk(0, 0, 3'b111, 3'b000, 6'd17, 6'd9,  6'd5, 32'h1000_0050, 32'h2000_0050, 3'b100);
      vecs[8]  = mk(0, 0, 3'b100, 3'b000, 6'd3,  6'd9,  6'd5, 32'hDEAD_BEED, 32'h2000_0060, 3'b100);
      vecs[9]  = mk(0, 0, 3'b011, 3'b000, 6'd3,  6'd9,  6'd5, 32'h0000_0012, 32'h2000_0070, 3'b001);
      vecs[10] = mk(0, 0, 3'b011, 3'b000, 6'd3,  6'd11, 6'd7, 32'h0000_0012, 32'h2000_0070, 3'b010);
      vecs[11] = mk(0, 0, 3'b001, 3'b000, 6'd3,  6'd11, 6'd7, 32'h0000_0012, 32'h2000_0070, 3'b001);
      vecs[12] = mk(0, 1, 3'b111, 3'b000, 6'd17, 6'd9,  6'd5, 32'h3000_0000, 32'h4000_0000, 3'b000);
      vecs[13] = mk(0, 0, 3'b111, 3'b000, 6'd17, 6'd9,  6'd5, 32'h3000_0000, 32'h4000_0000, 3'b010);
      vecs[14] = mk(0, 0, 3'b111, 3'b000, 6'd17, 6'd9,  6'd5, 32'h3000_0010, 32'h4000_0010, 3'b100);
      vecs[15] = mk(0, 0, 3'b001, 3'b000, 6'd17, 6'd9,  6'd20, 32'h3000_0020, 32'h4000_0020, 3'b001);
      vecs[16] = mk(0, 0, 3'b001, 3'b000, 6'd17, 6'd9,  6'd21, 32'h3000_0030, 32'h4000_0030, 3'b001);
      vecs[17] = mk(0, 0, 3'b000, 3'b000, 6'd17, 6'd9,  6'd21, 32'h3000_0040, 32'h4000_0040, 3'b000);
      vecs[18] = mk(0, 1, 3'b010, 3'b010, 6'd17, 6'd42, 6'd5, 32'h5000_0000, 32'h0000_00FC, 3'b000);
      vecs[19] = mk(0, 0, 3'b010, 3'b010, 6'd17, 6'd42, 6'd5, 32'h5000_0000, 32'h0000_00FC, 3'b010);
      vecs[20] = mk(1, 0, 3'b110, 3'b000, 6'd17, 6'd9,  6'd5, 32'h6000_0000, 32'h7000_0000, 3'b000);
      vecs[21] = mk(0, 0, 3'b110, 3'b000, 6'd17, 6'd9,  6'd5, 32'h6000_0000, 32'h7000_0000, 3'b010);
      vecs[22] = mk(0, 0, 3'b101, 3'b000, 6'd17, 6'd9,  6'd5, 32'h6000_0010, 32'h7000_0010, 3'b100);
      vecs[23] = mk(0, 0, 3'b101, 3'b000, 6'd17, 6'd9,  6'd5, 32'h6000_0020, 32'h7000_0020, 3'b001);

      rst = 1'b1; i_flush = 1'b0; i_req_valid = '0; i_req_redirect = '0;
      i_req_tag = '0; i_req_data = '0; i_req_addr = '0;
      last = '0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 24; i++) run_vec(vecs[i], i);

      // ptr is 1 after the table; a lone req0 must still stream back to back.
      for (int i = 0; i < 4; i++)
         run_vec(mk(0, 0, 3'b001, 3'b000, 6'd0, 6'd0, 6'(i + 30),
                    $urandom, $urandom, 3'b001), 100 + i);

      // Full contention from ptr=1, flush in the middle: the flush cycle's
      // broadcast stays visible and the rotation resumes where it stopped.
      run_vec(mk(0, 0, 3'b111, 3'b000, 6'd17, 6'd9, 6'd5, 32'h8000_0000, 32'h9000_0000, 3'b010), 200);
      run_vec(mk(0, 1, 3'b111, 3'b000, 6'd17, 6'd9, 6'd5, 32'h8000_0000, 32'h9000_0000, 3'b000), 201);
      run_vec(mk(0, 1, 3'b111, 3'b000, 6'd17, 6'd9, 6'd5, 32'h8000_0000, 32'h9000_0000, 3'b000), 202);
      run_vec(mk(0, 0, 3'b111, 3'b000, 6'd17, 6'd9, 6'd5, 32'h8000_0000, 32'h9000_0000, 3'b100), 203);
      run_vec(mk(0, 0, 3'b111, 3'b000, 6'd17, 6'd9, 6'd5, 32'h8000_0010, 32'h9000_0010, 3'b001), 204);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
